// File: rtl/rom_download_streamer.sv
// Streams host ROM-download words into a buffered queue and replays them as
// little-endian halfword writes over a req/ack memory handshake.
module rom_download_streamer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_mem,
  input  logic        reset_n,
  input  logic        dl_start,
  input  logic        dl_end,
  input  logic [31:0] rom_file_size,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  input  logic        mem_ack,
  output logic [24:0] addr,
  output logic [15:0] data,
  output logic        mem_wr,
  output logic        downloading,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    logic [22:0] waddr;
    logic [31:0] wdata;
  } entry_t;

  state_t      state;
  entry_t      fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] size_q;
  logic        half;

  entry_t      head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic [24:0] hw_addr;
  logic [15:0] hw_data;
  logic [32:0] size_even;
  logic        hw_valid;
  logic        advance;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bridge_addr[31:25], bridge_addr[1:0]};

  always_comb begin
    head       = fifo_mem[rd_ptr[AW-1:0]];
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push       = bridge_wr && (state == ACTIVE) && !fifo_full && !dl_start;
    hw_addr    = {head.waddr, half, 1'b0};
    hw_data    = half ? {head.wdata[7:0],   head.wdata[15:8]}
                      : {head.wdata[23:16], head.wdata[31:24]};
    size_even  = {1'b0, size_q} + {32'b0, size_q[0]};
    hw_valid   = ({8'b0, hw_addr} < size_even);
    // A halfword retires on its ack, or immediately when it lies past the file end.
    advance    = !fifo_empty && (mem_wr ? mem_ack : !hw_valid);
  end

  always_ff @(posedge clk_mem) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {bridge_addr[24:2], bridge_wr_data};
    end
  end

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_wr      <= 1'b0;
      downloading <= 1'b0;
      overflow    <= 1'b0;
      addr        <= '0;
      data        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      size_q      <= '0;
      half        <= 1'b0;
    end else if (dl_start) begin
      state       <= ACTIVE;
      downloading <= 1'b1;
      overflow    <= 1'b0;
      size_q      <= rom_file_size;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      half        <= 1'b0;
      mem_wr      <= 1'b0;
    end else begin
      // Full is judged before this cycle's pop, so a pop never makes room for a same-cycle write.
      if (bridge_wr && (state == ACTIVE)) begin
        if (fifo_full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
        end
      end

      if (advance) begin
        half <= ~half;
        if (half) begin
          rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
      end

      if (mem_wr) begin
        if (mem_ack) begin
          mem_wr <= 1'b0;
        end
      end else if (!fifo_empty && hw_valid) begin
        mem_wr <= 1'b1;
        addr   <= hw_addr;
        data   <= hw_data;
      end

      case (state)
        ACTIVE: begin
          if (dl_end) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !mem_wr) begin
            state       <= IDLE;
            downloading <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_download_streamer.sv
// Directed bench for rom_download_streamer: single-word vector table plus
// hand sequences for latency, overflow, stall, abort and reset.
module tb_rom_download_streamer;

  logic        clk_mem = 1'b0;
  logic        reset_n;
  logic        dl_start;
  logic        dl_end;
  logic [31:0] rom_file_size;
  logic        bridge_wr;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        mem_ack;
  logic [24:0] addr;
  logic [15:0] data;
  logic        mem_wr;
  logic        downloading;
  logic        overflow;

  rom_download_streamer #(.FIFO_DEPTH(4)) dut (
    .clk_mem        (clk_mem),
    .reset_n        (reset_n),
    .dl_start       (dl_start),
    .dl_end         (dl_end),
    .rom_file_size  (rom_file_size),
    .bridge_wr      (bridge_wr),
    .bridge_addr    (bridge_addr),
    .bridge_wr_data (bridge_wr_data),
    .mem_ack        (mem_ack),
    .addr           (addr),
    .data           (data),
    .mem_wr         (mem_wr),
    .downloading    (downloading),
    .overflow       (overflow)
  );

  always #5 clk_mem = ~clk_mem;

  typedef struct {
    logic [24:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] size;
    logic [31:0] baddr;
    logic [31:0] bdata;
    int          n;
    logic [24:0] a0;
    logic [15:0] d0;
    logic [24:0] a1;
    logic [15:0] d1;
  } vec_t;

  wr_t  log_q[$];
  int   total = 0;
  int   bad = 0;
  int   gap_err = 0;
  logic ack_prev = 1'b0;
  logic ack_en = 1'b0;

  // Memory model: acknowledges one edge after it sees a request.
  always @(negedge clk_mem) mem_ack = ack_en && mem_wr;

  always @(posedge clk_mem) begin
    if (ack_prev && mem_wr) gap_err++;
    ack_prev = mem_wr && mem_ack;
    if (mem_wr && mem_ack) log_q.push_back('{a: addr, d: data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [24:0] ea[8], input logic [15:0] ed[8]);
    check({tag, "_count"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(log_q[i].a), 64'(ea[i]));
        check($sformatf("%s_data%0d", tag, i), 64'(log_q[i].d), 64'(ed[i]));
      end else begin
        total++;
        bad++;
        $display("FAIL %s_missing%0d: actual=none expected=%0h/%0h", tag, i, ea[i], ed[i]);
      end
    end
  endtask

  task automatic start_dl(input logic [31:0] sz);
    dl_start = 1'b1;
    rom_file_size = sz;
    @(negedge clk_mem);
    dl_start = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    bridge_wr = 1'b1;
    bridge_addr = a;
    bridge_wr_data = d;
    @(negedge clk_mem);
    bridge_wr = 1'b0;
  endtask

  task automatic end_dl();
    dl_end = 1'b1;
    @(negedge clk_mem);
    dl_end = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && downloading; i++) @(negedge clk_mem);
    check({tag, "_idle"}, 64'(downloading), 64'(0));
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int i = 0; i < budget && !mem_wr; i++) @(negedge clk_mem);
    check({tag, "_req"}, 64'(mem_wr), 64'(1));
  endtask

  vec_t        vecs[8];
  logic [24:0] ea[8];
  logic [15:0] ed[8];
  logic [24:0] hold_a;
  logic [15:0] hold_d;
  int          stall_bad;

  initial begin
    reset_n = 1'b0;
    dl_start = 1'b0;
    dl_end = 1'b0;
    rom_file_size = '0;
    bridge_wr = 1'b0;
    bridge_addr = '0;
    bridge_wr_data = '0;
    mem_ack = 1'b0;

    vecs[0] = '{32'd8,       32'h0,        32'h11223344, 2, 25'h0,       16'h2211, 25'h2,       16'h4433};
    vecs[1] = '{32'h206,     32'h204,      32'hAABBCCDD, 1, 25'h204,     16'hBBAA, 25'h0,       16'h0};
    vecs[2] = '{32'h205,     32'h204,      32'hAABBCCDD, 1, 25'h204,     16'hBBAA, 25'h0,       16'h0};
    vecs[3] = '{32'h207,     32'h204,      32'hAABBCCDD, 2, 25'h204,     16'hBBAA, 25'h206,     16'hDDCC};
    vecs[4] = '{32'd4,       32'h4,        32'h01020304, 0, 25'h0,       16'h0,    25'h0,       16'h0};
    vecs[5] = '{32'd0,       32'h0,        32'h01020304, 0, 25'h0,       16'h0,    25'h0,       16'h0};
    vecs[6] = '{32'h2000000, 32'hFFFFFFFF, 32'hCAFEBABE, 2, 25'h1FFFFFC, 16'hFECA, 25'h1FFFFFE, 16'hBEBA};
    vecs[7] = '{32'd1,       32'h0,        32'hA1B2C3D4, 1, 25'h0,       16'hB2A1, 25'h0,       16'h0};

    repeat (3) @(negedge clk_mem);
    check("rst_mem_wr", 64'(mem_wr), 64'(0));
    check("rst_downloading", 64'(downloading), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    reset_n = 1'b1;
    @(negedge clk_mem);

    // Single-word table.
    ack_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      log_q.delete();
      start_dl(vecs[v].size);
      wr_word(vecs[v].baddr, vecs[v].bdata);
      end_dl();
      wait_idle($sformatf("vec%0d", v), 100);
      ea = '{default: '0};
      ed = '{default: '0};
      ea[0] = vecs[v].a0; ed[0] = vecs[v].d0;
      ea[1] = vecs[v].a1; ed[1] = vecs[v].d1;
      check_writes($sformatf("vec%0d", v), vecs[v].n, ea, ed);
      check($sformatf("vec%0d_ovf", v), 64'(overflow), 64'(0));
    end

    // Two words, with first-request latency.
    log_q.delete();
    start_dl(32'd8);
    check("a_dl_high", 64'(downloading), 64'(1));
    bridge_wr = 1'b1; bridge_addr = 32'h0; bridge_wr_data = 32'h11223344;
    @(negedge clk_mem);
    check("a_lat1_low", 64'(mem_wr), 64'(0));
    bridge_addr = 32'h4; bridge_wr_data = 32'h55667788;
    @(negedge clk_mem);
    check("a_lat2_high", 64'(mem_wr), 64'(1));
    check("a_first_addr", 64'(addr), 64'(0));
    check("a_first_data", 64'(data), 64'h2211);
    bridge_wr = 1'b0;
    end_dl();
    check("a_dl_after_end", 64'(downloading), 64'(1));
    wait_idle("a", 100);
    ea = '{25'h0, 25'h2, 25'h4, 25'h6, 25'h0, 25'h0, 25'h0, 25'h0};
    ed = '{16'h2211, 16'h4433, 16'h6655, 16'h8877, 16'h0, 16'h0, 16'h0, 16'h0};
    check_writes("a", 4, ea, ed);

    // Overflow: five words into four slots with acks held off.
    ack_en = 1'b0;
    log_q.delete();
    start_dl(32'h100);
    wr_word(32'h0,  32'h11223344);
    wr_word(32'h4,  32'h55667788);
    wr_word(32'h8,  32'h99AABBCC);
    wr_word(32'hC,  32'hDDEEFF00);
    wr_word(32'h10, 32'h12345678);
    check("b_overflow", 64'(overflow), 64'(1));
    ack_en = 1'b1;
    end_dl();
    wait_idle("b", 200);
    ea = '{25'h0, 25'h2, 25'h4, 25'h6, 25'h8, 25'hA, 25'hC, 25'hE};
    ed = '{16'h2211, 16'h4433, 16'h6655, 16'h8877, 16'hAA99, 16'hCCBB, 16'hEEDD, 16'h00FF};
    check_writes("b", 8, ea, ed);
    check("b_ovf_sticky", 64'(overflow), 64'(1));

    // Ten-cycle ack stall.
    ack_en = 1'b0;
    log_q.delete();
    start_dl(32'd8);
    check("c_ovf_cleared", 64'(overflow), 64'(0));
    wr_word(32'h0, 32'h11223344);
    end_dl();
    wait_req("c", 20);
    check("c_stall_addr", 64'(addr), 64'(0));
    check("c_stall_data", 64'(data), 64'h2211);
    hold_a = addr;
    hold_d = data;
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk_mem);
      if (mem_wr !== 1'b1 || addr !== hold_a || data !== hold_d) stall_bad++;
    end
    check("c_stall_hold", 64'(stall_bad), 64'(0));
    ack_en = 1'b1;
    wait_idle("c", 100);
    ea = '{25'h0, 25'h2, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0};
    ed = '{16'h2211, 16'h4433, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    check_writes("c", 2, ea, ed);

    // Restart while draining with two words queued.
    ack_en = 1'b0;
    log_q.delete();
    start_dl(32'h100);
    wr_word(32'h0, 32'h11223344);
    wr_word(32'h4, 32'h55667788);
    end_dl();
    @(negedge clk_mem);
    check("d_drain_dl", 64'(downloading), 64'(1));
    start_dl(32'h100);
    check("d_abort_mem_wr", 64'(mem_wr), 64'(0));
    check("d_abort_dl", 64'(downloading), 64'(1));
    check("d_abort_ovf", 64'(overflow), 64'(0));
    ack_en = 1'b1;
    repeat (10) @(negedge clk_mem);
    check("d_no_writes", 64'(log_q.size()), 64'(0));
    end_dl();
    wait_idle("d", 50);
    check("d_no_writes_end", 64'(log_q.size()), 64'(0));

    // dl_end coinciding with the last word.
    log_q.delete();
    start_dl(32'd8);
    bridge_wr = 1'b1; bridge_addr = 32'h0; bridge_wr_data = 32'h11223344;
    dl_end = 1'b1;
    @(negedge clk_mem);
    bridge_wr = 1'b0;
    dl_end = 1'b0;
    wait_idle("f", 100);
    check_writes("f", 2, ea, ed);

    // Asynchronous reset while a request is outstanding.
    ack_en = 1'b0;
    log_q.delete();
    start_dl(32'h100);
    wr_word(32'h0, 32'h11223344);
    wait_req("e", 20);
    #2 reset_n = 1'b0;
    #1;
    check("e_rst_mem_wr", 64'(mem_wr), 64'(0));
    check("e_rst_dl", 64'(downloading), 64'(0));
    check("e_rst_addr", 64'(addr), 64'(0));
    @(negedge clk_mem);
    reset_n = 1'b1;
    ack_en = 1'b1;
    repeat (10) @(negedge clk_mem);
    check("e_no_writes", 64'(log_q.size()), 64'(0));
    // Word and dl_end arriving while idle are ignored.
    bridge_wr = 1'b1; bridge_addr = 32'h0; bridge_wr_data = 32'h11223344;
    dl_end = 1'b1;
    @(negedge clk_mem);
    bridge_wr = 1'b0;
    dl_end = 1'b0;
    repeat (6) @(negedge clk_mem);
    check("e_idle_dl", 64'(downloading), 64'(0));
    check("e_idle_mem_wr", 64'(mem_wr), 64'(0));
    check("e_idle_no_writes", 64'(log_q.size()), 64'(0));

    check("ack_gap", 64'(gap_err), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_download_streamer.md
ROM_DOWNLOAD_STREAMER -- requirements
Module: rom_download_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 32-bit bridge words buffered (power of 2, min 2).
REQ-002 SHALL have port clk_mem, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port dl_start, input, 1, a one-cycle pulse that begins a ROM download.
REQ-005 SHALL have port dl_end, input, 1, a one-cycle pulse meaning the host has sent its last word.
REQ-006 SHALL have port rom_file_size, input, 32, the file length in bytes, header included; sampled on dl_start.
REQ-007 SHALL have port bridge_wr, input, 1, a one-cycle word-write strobe.
REQ-008 SHALL have port bridge_addr, input, 32, the byte address of the word; bits [1:0] are ignored.
REQ-009 SHALL have port bridge_wr_data, input, 32, big-endian data: [31:24] is the byte at addr+0.
REQ-010 SHALL have port mem_ack, input, 1, the downstream write acknowledge.
REQ-011 SHALL have port addr, output, 25, the file byte offset of the current halfword (always even).
REQ-012 SHALL have port data, output, 16, the little-endian halfword: [7:0] = byte at addr, [15:8] = byte at addr+1.
REQ-013 SHALL have port mem_wr, output, 1, the write request.
REQ-014 SHALL have port downloading, output, 1, high while a download is in progress.
REQ-015 SHALL have port overflow, output, 1, a sticky flag set when a word is dropped.

Function
REQ-016 SHALL implement states IDLE, ACTIVE and DRAIN. IDLE->ACTIVE on dl_start. ACTIVE->DRAIN on dl_end. DRAIN->IDLE when the FIFO is empty, no halfword is pending and mem_wr is low.
REQ-017 SHALL set downloading to 1 the cycle after dl_start and clear it on the cycle the state enters IDLE. downloading SHALL be 1 in ACTIVE and DRAIN.
REQ-018 SHALL, on dl_start, flush the FIFO, clear overflow and latch rom_file_size.
REQ-019 SHALL push {bridge_addr[24:2], bridge_wr_data} into the FIFO on bridge_wr in ACTIVE, and SHALL ignore bridge_wr in IDLE and DRAIN.
REQ-020 SHALL drop the word and set overflow on bridge_wr when the FIFO is full. A simultaneous pop SHALL NOT free a slot for that same-cycle push.
REQ-021 SHALL split each FIFO word into two halfwords, in this order:
  - first: addr = word_addr*4, data = {wr_data[23:16], wr_data[31:24]};
  - second: addr = word_addr*4 + 2, data = {wr_data[7:0], wr_data[15:8]}.
REQ-022 SHALL suppress (never issue) any halfword with addr >= the latched rom_file_size rounded up to even.
REQ-023 SHALL follow the request/acknowledge handshake:
  - mem_wr rises with addr and data stable, and holds until mem_ack is sampled high;
  - mem_wr SHALL be low for at least one cycle after each ack;
  - mem_ack while mem_wr is low SHALL be ignored.
REQ-024 SHALL raise mem_wr no earlier than 2 cycles after the bridge_wr that pushes into an empty FIFO (minimum latency 2).
REQ-025 SHALL pop a FIFO word only after its second halfword is acked or suppressed.
REQ-026 SHALL let dl_start in ACTIVE or DRAIN abort the current download: FIFO flushed, mem_wr dropped, restart in ACTIVE, downloading held at 1.
REQ-027 SHALL ignore dl_end in IDLE. When dl_end and bridge_wr occur in the same cycle, the word SHALL be accepted before entering DRAIN.
REQ-028 SHALL hold addr and data at their last values when mem_wr is low.

Reset
REQ-029 SHALL, while reset_n is low, asynchronously force:
  - state = IDLE;
  - mem_wr = 0, downloading = 0, overflow = 0;
  - addr = 0, data = 0;
  - FIFO empty, latched size = 0.
REQ-030 SHALL, when reset_n asserts mid-download, discard in-flight data without issuing any further write.

Verification
REQ-031 SHALL pass this test: dl_start, size = 8; words 0x0:0x11223344 and 0x4:0x55667788; mem_ack one cycle after each mem_wr. Expected writes: (0x000,0x2211), (0x002,0x4433), (0x004,0x6655), (0x006,0x8877). downloading falls after dl_end and the final ack.
REQ-032 SHALL pass this test: size = 0x206; word at 0x204 = 0xAABBCCDD. Expected: only (0x204,0xBBAA) is issued; 0x206 is suppressed.
REQ-033 SHALL pass this test: mem_ack held low, 5 back-to-back bridge_wr with FIFO_DEPTH = 4. Expected: overflow = 1, the 5th word is never written, and the first 4 words are emitted in order once acks resume.
REQ-034 SHALL pass this test: mem_ack stalled 10 cycles. Expected: mem_wr, addr and data stay constant throughout the stall; exactly one write per ack.
REQ-035 SHALL pass this test: dl_start during DRAIN with 2 words queued. Expected: the queued words are never written, downloading stays 1 and overflow = 0.
REQ-036 SHALL pass this test: reset_n pulsed low while mem_wr = 1. Expected: mem_wr = 0 and downloading = 0 immediately, and no writes until the next dl_start.
